// File: rtl/fetch_queue.sv
// Dual-issue fetch unit: drives the imem request/ack port and buffers returned
// instruction pairs in a small FIFO feeding the decoder; a PC redirect flushes it.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = '0,
  parameter logic [31:0] STRIDE   = 32'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata0,
  input  logic [31:0] mem_rdata1,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst0,
  output logic [31:0] dec_inst1,
  output logic [31:0] dec_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     pend_q, pend_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     inst0_q [DEPTH];
  logic [31:0]     inst0_d [DEPTH];
  logic [31:0]     inst1_q [DEPTH];
  logic [31:0]     inst1_d [DEPTH];
  logic [31:0]     pc_q    [DEPTH];
  logic [31:0]     pc_d    [DEPTH];
  logic            push, pop, has_space;

  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign dec_valid = (count_q != '0);
  assign dec_inst0 = dec_valid ? inst0_q[rptr_q] : '0;
  assign dec_inst1 = dec_valid ? inst1_q[rptr_q] : '0;
  assign dec_pc    = dec_valid ? pc_q[rptr_q]    : '0;

  always_comb begin
    push    = (state_q == REQ) && mem_ack && !redirect_en;
    pop     = dec_valid && dec_ready && !redirect_en;
    inst0_d = inst0_q;
    inst1_d = inst1_q;
    pc_d    = pc_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;

    if (push) begin
      inst0_d[wptr_q] = mem_rdata0;
      inst1_d[wptr_q] = mem_rdata1;
      pc_d[wptr_q]    = addr_q;
      wptr_d          = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;

    if (redirect_en) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // Equals (count+1-pop)<DEPTH after a push; a redirect always leaves room.
    has_space = (count_d < CW'(DEPTH));

    case (state_q)
      IDLE: begin
        if (redirect_en) addr_d = redirect_pc;
        if (redirect_en || (count_q < CW'(DEPTH))) state_d = REQ;
      end
      REQ: begin
        if (mem_ack) begin
          addr_d  = redirect_en ? redirect_pc : addr_q + STRIDE;
          state_d = has_space ? REQ : IDLE;
        end else if (redirect_en) begin
          pend_d  = redirect_pc;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect_en) pend_d = redirect_pc;
        if (mem_ack) begin
          addr_d  = redirect_en ? redirect_pc : pend_q;
          state_d = has_space ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      pend_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst0_q[i] <= '0;
        inst1_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      inst0_q <= inst0_d;
      inst1_q <= inst1_d;
      pc_q    <= pc_d;
    end
  end

endmodule
